// File: rtl/debounce_pkg.sv
// Shared types and helpers for the front-panel key conditioner.
// Holds the per-channel hold-state encoding and the counter-width helper.
package debounce_pkg;

   typedef enum logic [1:0] {
      HS_IDLE   = 2'd0,
      HS_HOLD   = 2'd1,
      HS_REPEAT = 2'd2
   } hold_state_e;

   // Bits needed to hold any value in 0..max_val (always at least 1).
   function automatic int cnt_width(input int max_val);
      int w;
      w = 1;
      while ((w < 31) && ((1 << w) <= max_val)) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One key channel: synchroniser, debounce filter, press/release strobes and the
// hold FSM that produces long-press and auto-repeat strobes from the shared ms tick.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int DB_CYC       = 500,
   parameter int LONG_TICKS   = 1000,
   parameter int REPEAT_TICKS = 200,
   parameter int SYNC_STG     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_in,
   input  logic        ms_tick,
   output logic        btn_level,
   output logic        press_p,
   output logic        release_p,
   output logic        long_p,
   output logic        repeat_p,
   output hold_state_e hold_state
);

   localparam int HC_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
   localparam int DB_W   = cnt_width(DB_CYC);
   localparam int HC_W   = cnt_width(HC_MAX);
   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYC - 1);
   localparam logic [HC_W-1:0] LONG_LAST = HC_W'(LONG_TICKS - 1);
   localparam logic [HC_W-1:0] REP_LAST  = HC_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
   localparam bit              REPEAT_EN = (REPEAT_TICKS > 0);

   logic [SYNC_STG-1:0] sync_q;
   logic                sync_s;
   logic                stable_q;
   logic [DB_W-1:0]     db_cnt_q;
   logic                accept;
   logic                acc_press;
   logic                acc_release;
   logic                press_q;
   logic                release_q;

   assign sync_s      = sync_q[SYNC_STG-1];
   assign accept      = (sync_s != stable_q) && (db_cnt_q == DB_LAST);
   assign acc_press   = accept && sync_s;
   assign acc_release = accept && !sync_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STG-2:0], btn_in};
   end

   // Any sample equal to the accepted level restarts the stability count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_q  <= 1'b0;
         db_cnt_q  <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         press_q   <= acc_press;
         release_q <= acc_release;
         if (sync_s == stable_q) begin
            db_cnt_q <= '0;
         end else if (accept) begin
            stable_q <= sync_s;
            db_cnt_q <= '0;
         end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
         end
      end
   end

   hold_state_e     state_q, state_d;
   logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
   logic            long_fired_q, long_fired_d;
   logic            long_q, long_d;
   logic            repeat_q, repeat_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= HS_IDLE;
         hold_cnt_q   <= '0;
         long_fired_q <= 1'b0;
         long_q       <= 1'b0;
         repeat_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         long_fired_q <= long_fired_d;
         long_q       <= long_d;
         repeat_q     <= repeat_d;
      end
   end

   // Release is checked first so it suppresses a coincident long/repeat strobe.
   // long_fired freezes HOLD after the long strobe when repeat is disabled.
   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      long_fired_d = long_fired_q;
      long_d       = 1'b0;
      repeat_d     = 1'b0;
      if (acc_release) begin
         state_d      = HS_IDLE;
         hold_cnt_d   = '0;
         long_fired_d = 1'b0;
      end else begin
         case (state_q)
            HS_IDLE: begin
               if (acc_press) begin
                  state_d      = HS_HOLD;
                  hold_cnt_d   = '0;
                  long_fired_d = 1'b0;
               end
            end
            HS_HOLD: begin
               if (ms_tick && !long_fired_q) begin
                  if (hold_cnt_q == LONG_LAST) begin
                     long_d     = 1'b1;
                     hold_cnt_d = '0;
                     if (REPEAT_EN) state_d = HS_REPEAT;
                     else           long_fired_d = 1'b1;
                  end else begin
                     hold_cnt_d = hold_cnt_q + HC_W'(1);
                  end
               end
            end
            HS_REPEAT: begin
               if (ms_tick) begin
                  if (hold_cnt_q == REP_LAST) begin
                     repeat_d   = 1'b1;
                     hold_cnt_d = '0;
                  end else begin
                     hold_cnt_d = hold_cnt_q + HC_W'(1);
                  end
               end
            end
            default: state_d = HS_IDLE;
         endcase
      end
   end

   assign btn_level  = stable_q;
   assign press_p    = press_q;
   assign release_p  = release_q;
   assign long_p     = long_q;
   assign repeat_p   = repeat_q;
   assign hold_state = state_q;

endmodule

// File: rtl/debounce_multi.sv
// N-channel key conditioner: one shared millisecond prescaler feeding N
// independent debounce/hold channels that emit one-cycle strobes.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int CLK_HZ      = 50_000_000,
   parameter int DEBOUNCE_US = 500,
   parameter int LONG_MS     = 1000,
   parameter int REPEAT_MS   = 200,
   parameter int SYNC_STG    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   btn_in,
   output logic [N_CH-1:0]   btn_level,
   output logic [N_CH-1:0]   press_p,
   output logic [N_CH-1:0]   release_p,
   output logic [N_CH-1:0]   long_p,
   output logic [N_CH-1:0]   repeat_p,
   output logic [2*N_CH-1:0] hold_state_dbg
);

   localparam int DB_CYC = CLK_HZ / 1_000_000 * DEBOUNCE_US;
   localparam int MS_CYC = CLK_HZ / 1000;
   localparam int PS_W   = cnt_width(MS_CYC);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(MS_CYC - 1);

   logic [PS_W-1:0] ps_cnt_q;
   logic            ms_tick;

   // Free-running so every channel shares one tick; hold timing is therefore +0/-1 ms.
   assign ms_tick = (ps_cnt_q == PS_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          ps_cnt_q <= '0;
      else if (ms_tick) ps_cnt_q <= '0;
      else              ps_cnt_q <= ps_cnt_q + PS_W'(1);
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      hold_state_e ch_state;

      debounce_chan #(
         .DB_CYC       (DB_CYC),
         .LONG_TICKS   (LONG_MS),
         .REPEAT_TICKS (REPEAT_MS),
         .SYNC_STG     (SYNC_STG)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .btn_in     (btn_in[i]),
         .ms_tick    (ms_tick),
         .btn_level  (btn_level[i]),
         .press_p    (press_p[i]),
         .release_p  (release_p[i]),
         .long_p     (long_p[i]),
         .repeat_p   (repeat_p[i]),
         .hold_state (ch_state)
      );

      assign hold_state_dbg[2*i +: 2] = ch_state;
   end

endmodule
